// File: rtl/lfsr_checker.sv
// Locks onto a received 8-bit Galois LFSR sequence, then flags and counts mispredicted words.
// State | Meaning
// ST_SEARCH | seeding from received words and counting consecutive correct predictions
// ST_LOCKED | free-running prediction; mismatches pulse err and may drop lock
module lfsr_checker #(
  parameter logic [7:0]  TAPS       = 8'h1D,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  lfsr_in,
  input  logic        in_en,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count,
  output logic [7:0]  expected
);

  localparam logic [3:0] LOCK_CNT_L   = LOCK_CNT[3:0];
  localparam logic [3:0] MISS_LIMIT_L = MISS_LIMIT[3:0];

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        have_seed_q, have_seed_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;
  logic [7:0]  pred_q, pred_d;
  logic        err_q, err_d;
  logic [15:0] err_count_q, err_count_d;

  logic        hit;
  logic [3:0]  match_inc;
  logic [3:0]  miss_inc;

  function automatic logic [7:0] step(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? TAPS : 8'h00);
  endfunction

  assign hit       = (lfsr_in == pred_q);
  assign match_inc = match_cnt_q + 4'd1;
  assign miss_inc  = miss_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    have_seed_d = have_seed_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    pred_d      = pred_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;

    if (in_en) begin
      case (state_q)
        ST_SEARCH: begin
          if (lfsr_in == 8'h00) begin
            // all-zero can never appear in a running LFSR, so it invalidates the seed
            match_cnt_d = 4'd0;
            have_seed_d = 1'b0;
          end else if (have_seed_q && hit) begin
            pred_d = step(lfsr_in);
            if (match_inc == LOCK_CNT_L) begin
              state_d     = ST_LOCKED;
              miss_cnt_d  = 4'd0;
              match_cnt_d = 4'd0;
            end else begin
              match_cnt_d = match_inc;
            end
          end else begin
            pred_d      = step(lfsr_in);
            have_seed_d = 1'b1;
            match_cnt_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          pred_d = step(pred_q);
          if (hit) begin
            miss_cnt_d = 4'd0;
          end else begin
            err_d = 1'b1;
            if (err_count_q != 16'hFFFF) begin
              err_count_d = err_count_q + 16'd1;
            end
            if (miss_inc == MISS_LIMIT_L) begin
              state_d     = ST_SEARCH;
              have_seed_d = 1'b0;
              match_cnt_d = 4'd0;
              miss_cnt_d  = 4'd0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    if (clr_cnt) begin
      err_count_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SEARCH;
      have_seed_q <= 1'b0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      pred_q      <= 8'h00;
      err_q       <= 1'b0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      have_seed_q <= have_seed_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      pred_q      <= pred_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign err       = err_q;
  assign err_count = err_count_q;
  assign expected  = pred_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized self-checking bench for lfsr_checker against a behavioural sequence model.
module tb_lfsr_checker;

  localparam int TAPS_I     = 'h1D;
  localparam int LOCK_CNT   = 4;
  localparam int MISS_LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  lfsr_in = 8'h00;
  logic        in_en = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err;
  logic [15:0] err_count;
  logic [7:0]  expected;

  logic        s_reset = 1'b1;
  logic [7:0]  s_in = 8'h00;
  logic        s_en = 1'b0;
  logic        s_clr = 1'b0;
  logic        s_locked, s_err;
  logic [15:0] s_err_count;
  logic [7:0]  s_expected;

  int n_checks = 0;
  int n_errors = 0;

  // reference model of the main instance
  bit m_locked, m_seed, m_err;
  int m_run, m_miss, m_pred, m_cnt;
  int obs_pulses, exp_pulses;

  always #5 clk = ~clk;

  lfsr_checker u_dut (
    .clk(clk), .reset(reset), .lfsr_in(lfsr_in), .in_en(in_en), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_count(err_count), .expected(expected)
  );

  lfsr_checker #(.MISS_LIMIT(15)) u_sat (
    .clk(clk), .reset(s_reset), .lfsr_in(s_in), .in_en(s_en), .clr_cnt(s_clr),
    .locked(s_locked), .err(s_err), .err_count(s_err_count), .expected(s_expected)
  );

  function automatic int stepf(input int x);
    int y;
    y = (x * 2) % 256;
    if (x >= 128) y = y ^ TAPS_I;
    return y;
  endfunction

  task automatic model_step(input int w, input bit en, input bit clr, input bit rst);
    if (rst) begin
      m_locked = 0; m_seed = 0; m_err = 0;
      m_run = 0; m_miss = 0; m_pred = 0; m_cnt = 0;
      return;
    end
    m_err = 0;
    if (en) begin
      if (m_locked) begin
        bit correct;
        correct = (w == m_pred);
        m_pred = stepf(m_pred);
        if (correct) m_miss = 0;
        else begin
          m_err = 1;
          m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
          m_miss++;
          if (m_miss == MISS_LIMIT) begin
            m_locked = 0; m_seed = 0; m_run = 0; m_miss = 0;
          end
        end
      end else if (w == 0) begin
        m_seed = 0; m_run = 0;
      end else if (m_seed && w == m_pred) begin
        m_pred = stepf(w);
        m_run++;
        if (m_run == LOCK_CNT) begin
          m_locked = 1; m_miss = 0; m_run = 0;
        end
      end else begin
        m_pred = stepf(w); m_seed = 1; m_run = 0;
      end
    end
    if (clr) m_cnt = 0;
  endtask

  task automatic do_cycle(input int w, input bit en, input bit clr, input bit rst);
    lfsr_in = 8'(w); in_en = en; clr_cnt = clr; reset = rst;
    @(posedge clk);
    model_step(w, en, clr, rst);
    #1;
    obs_pulses += int'(err);
    exp_pulses += int'(m_err);
  endtask

  task automatic feed_lock_seq();
    int seq[5] = '{'hFF, 'hE3, 'hDB, 'hAB, 'h4B};
    foreach (seq[i]) do_cycle(seq[i], 1, 0, 0);
  endtask

  function automatic int wrong_word(input int p);
    return (p ^ (1 + $urandom_range(0, 254))) % 256;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) do_cycle($urandom_range(0, 255), 1, 1'($urandom_range(0, 1)), 1);
    do_cycle(0, 0, 0, 0);
    n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (err_count !== 16'h0) begin n_errors++; $display("FAIL reset_err_count: got %h want 0000", err_count); end
    n_checks++; if (expected !== 8'h00) begin n_errors++; $display("FAIL reset_expected: got %h want 00", expected); end
    obs_pulses = 0; exp_pulses = 0;
  endtask

  task automatic test_lock();
    int seq[5] = '{'hFF, 'hE3, 'hDB, 'hAB, 'h4B};
    for (int i = 0; i < 5; i++) begin
      do_cycle(seq[i], 1, 0, 0);
      if (i == 3) begin
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL lock_early: got %b want 0", locked); end
      end
    end
    n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL lock_locked: got %b want 1", locked); end
    n_checks++; if (expected !== 8'h96) begin n_errors++; $display("FAIL lock_expected: got %h want 96", expected); end
    n_checks++; if (obs_pulses != 0) begin n_errors++; $display("FAIL lock_no_err: got %0d pulses want 0", obs_pulses); end
  endtask

  task automatic test_single_error();
    logic [7:0] want;
    do_cycle(0, 1, 0, 0);
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL single_err_pulse: got %b want 1", err); end
    n_checks++; if (err_count !== 16'd1) begin n_errors++; $display("FAIL single_err_count: got %0d want 1", err_count); end
    do_cycle(m_pred, 1, 0, 0);
    n_checks++; if (err !== 1'b0 || locked !== 1'b1) begin n_errors++; $display("FAIL single_recover: got err=%b locked=%b want err=0 locked=1", err, locked); end
    // two more misses would drop lock only if the earlier miss was not forgiven
    do_cycle(wrong_word(m_pred), 1, 0, 0);
    do_cycle(wrong_word(m_pred), 1, 0, 0);
    n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL single_miss_reset: got locked=%b want 1", locked); end
    want = 8'(m_pred);
    n_checks++; if (expected !== want) begin n_errors++; $display("FAIL single_expected: got %h want %h", expected, want); end
    do_cycle(m_pred, 1, 0, 0);
  endtask

  task automatic test_loss_of_lock();
    int p0;
    p0 = obs_pulses;
    for (int i = 0; i < 3; i++) begin
      do_cycle(wrong_word(m_pred), 1, 0, 0);
      if (i == 1) begin
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL loss_early: got %b want 1", locked); end
      end
    end
    n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL loss_locked: got %b want 0", locked); end
    n_checks++; if (obs_pulses - p0 != 3) begin n_errors++; $display("FAIL loss_pulses: got %0d want 3", obs_pulses - p0); end
    n_checks++; if (int'(err_count) != m_cnt) begin n_errors++; $display("FAIL loss_err_count: got %0d want %0d", err_count, m_cnt); end
    feed_lock_seq();
    n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL loss_relock: got %b want 1", locked); end
  endtask

  task automatic test_search_corners();
    do_cycle(0, 0, 0, 1);
    do_cycle('hFF, 1, 0, 0);
    do_cycle('h00, 1, 0, 0);
    do_cycle('hE3, 1, 0, 0);
    do_cycle('hDB, 1, 0, 0);
    do_cycle('hAB, 1, 0, 0);
    do_cycle('h4B, 1, 0, 0);
    n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL zero_clears_seed: got %b want 0", locked); end
    do_cycle('h96, 1, 0, 0);
    n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL zero_then_lock: got %b want 1", locked); end

    do_cycle(0, 0, 0, 1);
    do_cycle('hFF, 1, 0, 0);
    do_cycle('h12, 0, 0, 0);
    do_cycle('hE3, 1, 0, 0);
    do_cycle('h00, 0, 0, 0);
    do_cycle('h77, 0, 0, 0);
    do_cycle('hDB, 1, 0, 0);
    do_cycle('hAB, 1, 0, 0);
    do_cycle('h55, 0, 0, 0);
    n_checks++; if (err !== 1'b0 || locked !== 1'b0) begin n_errors++; $display("FAIL gap_idle: got err=%b locked=%b want 0 0", err, locked); end
    do_cycle('h4B, 1, 0, 0);
    n_checks++; if (locked !== 1'b1 || expected !== 8'h96) begin n_errors++; $display("FAIL gap_lock: got locked=%b exp=%h want 1 96", locked, expected); end

    do_cycle(wrong_word(m_pred), 1, 0, 0);
    do_cycle(wrong_word(m_pred), 1, 1, 0);
    n_checks++; if (err !== 1'b1 || err_count !== 16'd0) begin n_errors++; $display("FAIL clr_priority: got err=%b cnt=%0d want 1 0", err, err_count); end
    do_cycle(m_pred, 1, 0, 0);
  endtask

  task automatic test_random();
    int w, r;
    bit en, clr, rst;
    logic [7:0] want_exp;
    logic [15:0] want_cnt;
    int bad = 0;
    do_cycle(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) w = m_pred;
      else if (r < 70) w = 0;
      else w = $urandom_range(1, 255);
      if (!m_locked && !m_seed && $urandom_range(0, 3) == 0) w = $urandom_range(1, 255);
      en  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 299) == 0);
      do_cycle(w, en, clr, rst);
      want_exp = 8'(m_pred);
      want_cnt = 16'(m_cnt);
      n_checks++;
      if (locked !== m_locked || err !== m_err || err_count !== want_cnt || expected !== want_exp) begin
        n_errors++;
        if (bad < 10) $display("FAIL random_cycle%0d: got locked=%b err=%b cnt=%0d exp=%h want %b %b %0d %h",
                               i, locked, err, err_count, expected, m_locked, m_err, want_cnt, want_exp);
        bad++;
      end
    end
  endtask

  task automatic sat_cycle(input int w, inout int s_obs);
    s_in = 8'(w); s_en = 1'b1;
    @(posedge clk);
    #1;
    s_obs += int'(s_err);
  endtask

  task automatic test_saturation();
    int seq[5] = '{'hFF, 'hE3, 'hDB, 'hAB, 'h4B};
    int spred, issued, s_obs, batch;
    bit mid_done, drop_done;
    issued = 0; s_obs = 0; batch = 0; mid_done = 0; drop_done = 0;
    s_reset = 1'b1; s_en = 1'b0;
    @(posedge clk); #1;
    s_reset = 1'b0;
    foreach (seq[i]) sat_cycle(seq[i], s_obs);
    spred = 'h96;
    while (issued < 70000) begin
      if (batch % 1000 == 999) begin
        for (int k = 0; k < 15; k++) begin
          sat_cycle(spred ^ 'h5A, s_obs);
          spred = stepf(spred);
          issued++;
        end
        if (!drop_done) begin
          drop_done = 1;
          n_checks++; if (s_locked !== 1'b0) begin n_errors++; $display("FAIL sat_drop: got %b want 0", s_locked); end
        end
        foreach (seq[i]) sat_cycle(seq[i], s_obs);
        spred = 'h96;
      end else begin
        for (int k = 0; k < 15; k++) begin
          sat_cycle((k < 14) ? (spred ^ 'h5A) : spred, s_obs);
          spred = stepf(spred);
          if (k < 14) issued++;
        end
      end
      batch++;
      if (!mid_done && issued >= 28) begin
        mid_done = 1;
        n_checks++; if (int'(s_err_count) != issued) begin n_errors++; $display("FAIL sat_mid_count: got %0d want %0d", s_err_count, issued); end
      end
    end
    s_en = 1'b0;
    n_checks++; if (s_err_count !== 16'hFFFF) begin n_errors++; $display("FAIL sat_count: got %h want ffff", s_err_count); end
    n_checks++; if (s_obs != issued) begin n_errors++; $display("FAIL sat_pulses: got %0d want %0d", s_obs, issued); end
    n_checks++; if (s_locked !== 1'b1) begin n_errors++; $display("FAIL sat_locked: got %b want 1", s_locked); end
  endtask

  initial begin
    obs_pulses = 0; exp_pulses = 0;
    model_step(0, 0, 0, 1);
    test_reset();
    test_lock();
    test_single_error();
    test_loss_of_lock();
    test_search_corners();
    n_checks++; if (obs_pulses != exp_pulses) begin n_errors++; $display("FAIL directed_pulses: got %0d want %0d", obs_pulses, exp_pulses); end
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
